// File: rtl/fetch_arbiter_pkg.sv
// Shared types and default sizing for the operand-SRAM fetch arbiter.
package fetch_arbiter_pkg;

    localparam int FA_ADDR_W = 16;
    localparam int FA_DATA_W = 64;
    localparam int FA_W_LEN  = 8;
    localparam int FA_IF_LEN = 8;
    localparam int FA_RD_LAT = 2;

    typedef enum logic {FA_W = 1'b0, FA_IF = 1'b1} fa_owner_e;

    typedef struct packed {
        logic      valid;
        fa_owner_e owner;
        logic      gen;
    } fa_tag_t;

    typedef enum logic [1:0] {FA_IDLE, FA_ISSUE, FA_DRAIN, FA_DONE} fa_state_e;

    // Index width for a tile; a one-word tile still gets a 1-bit index.
    function automatic int fa_idx_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/fetch_stream.sv
// One fetch stream: tile state machine, address generation, and return
// accounting with a generation bit to reject returns from a cleared tile.
module fetch_stream
    import fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W = FA_ADDR_W,
    parameter int LEN    = FA_W_LEN,
    parameter int IDX_W  = fa_idx_w(FA_W_LEN)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_read,
    input  logic              i_grant,
    input  logic              i_ret,
    input  logic              i_ret_gen,
    output logic              o_elig,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_gen,
    output logic              o_we,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_done
);

    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [1:0] ST_IDLE  = 2'(FA_IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(FA_ISSUE);
    localparam logic [1:0] ST_DRAIN = 2'(FA_DRAIN);
    localparam logic [1:0] ST_DONE  = 2'(FA_DONE);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_icnt;
    logic [CNT_W-1:0]  r_rcnt;
    logic              r_gen;
    logic              r_done;

    assign o_elig = (r_state == ST_ISSUE) && i_read && !i_clr;
    assign o_addr = r_base + ADDR_W'(r_icnt);
    assign o_gen  = r_gen;
    // A return racing a clear belongs to the old tile and is dropped.
    assign o_we   = i_ret && (i_ret_gen == r_gen) && !i_clr && !i_rst;
    assign o_idx  = IDX_W'(r_rcnt);
    assign o_done = r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_icnt  <= '0;
            r_rcnt  <= '0;
            r_gen   <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_clr) begin
            r_state <= ST_ISSUE;
            r_base  <= i_base;
            r_icnt  <= '0;
            r_rcnt  <= '0;
            r_gen   <= ~r_gen;
            r_done  <= 1'b0;
        end else begin
            if (i_grant) begin
                r_icnt <= r_icnt + 1'b1;
                if (r_icnt == CNT_W'(LEN - 1))
                    r_state <= ST_DRAIN;
            end
            if (o_we) begin
                r_rcnt <= r_rcnt + 1'b1;
                if (r_rcnt == CNT_W'(LEN - 1)) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin sharing of the SRAM read port between weight and IF fetch,
// with a tag pipe that steers fixed-latency returns to the right buffer.
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W = FA_ADDR_W,
    parameter int DATA_W = FA_DATA_W,
    parameter int W_LEN  = FA_W_LEN,
    parameter int IF_LEN = FA_IF_LEN,
    parameter int RD_LAT = FA_RD_LAT
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clr_w,
    input  logic                        i_clr_if,
    input  logic [ADDR_W-1:0]           i_w_base,
    input  logic [ADDR_W-1:0]           i_if_base,
    input  logic                        i_w_read,
    input  logic                        i_if_read,
    output logic                        o_mem_req,
    output logic [ADDR_W-1:0]           o_mem_addr,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic                        o_w_buf_we,
    output logic                        o_if_buf_we,
    output logic [DATA_W-1:0]           o_buf_wdata,
    output logic [fa_idx_w(W_LEN)-1:0]  o_w_buf_idx,
    output logic [fa_idx_w(IF_LEN)-1:0] o_if_buf_idx,
    output logic                        o_w_done,
    output logic                        o_if_done
);

    logic              w_w_elig, w_if_elig;
    logic              w_w_grant, w_if_grant, w_any_grant;
    logic              w_w_gen, w_if_gen;
    logic [ADDR_W-1:0] w_w_addr, w_if_addr;
    fa_tag_t           w_ret;
    logic              r_prio_if;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    fa_tag_t           r_tag [RD_LAT+1];

    // r_prio_if set means IF wins a tie; weights hold priority out of reset.
    assign w_w_grant   = w_w_elig && !(w_if_elig && r_prio_if);
    assign w_if_grant  = w_if_elig && !(w_w_elig && !r_prio_if);
    assign w_any_grant = w_w_grant || w_if_grant;
    assign w_ret       = r_tag[RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio_if  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            for (int i = 0; i <= RD_LAT; i++)
                r_tag[i] <= '0;
        end else begin
            if (w_any_grant) begin
                r_prio_if  <= w_w_grant;
                r_mem_addr <= w_w_grant ? w_w_addr : w_if_addr;
            end
            r_mem_req <= w_any_grant;
            // Stage 0 lines up with mem_req, stage RD_LAT with mem_rdata.
            r_tag[0]  <= '{valid: w_any_grant,
                           owner: w_w_grant ? FA_W : FA_IF,
                           gen:   w_w_grant ? w_w_gen : w_if_gen};
            for (int i = 1; i <= RD_LAT; i++)
                r_tag[i] <= r_tag[i-1];
        end
    end

    fetch_stream #(.ADDR_W(ADDR_W), .LEN(W_LEN), .IDX_W(fa_idx_w(W_LEN))) u_w_stream (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_clr_w),
        .i_base    (i_w_base),
        .i_read    (i_w_read),
        .i_grant   (w_w_grant),
        .i_ret     (w_ret.valid && (w_ret.owner == FA_W)),
        .i_ret_gen (w_ret.gen),
        .o_elig    (w_w_elig),
        .o_addr    (w_w_addr),
        .o_gen     (w_w_gen),
        .o_we      (o_w_buf_we),
        .o_idx     (o_w_buf_idx),
        .o_done    (o_w_done)
    );

    fetch_stream #(.ADDR_W(ADDR_W), .LEN(IF_LEN), .IDX_W(fa_idx_w(IF_LEN))) u_if_stream (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (i_clr_if),
        .i_base    (i_if_base),
        .i_read    (i_if_read),
        .i_grant   (w_if_grant),
        .i_ret     (w_ret.valid && (w_ret.owner == FA_IF)),
        .i_ret_gen (w_ret.gen),
        .o_elig    (w_if_elig),
        .o_addr    (w_if_addr),
        .o_gen     (w_if_gen),
        .o_we      (o_if_buf_we),
        .o_idx     (o_if_buf_idx),
        .o_done    (o_if_done)
    );

    assign o_mem_req   = r_mem_req;
    assign o_mem_addr  = r_mem_addr;
    assign o_buf_wdata = i_mem_rdata;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Scoreboard bench: a tile-level reference model predicts SRAM requests,
// buffer writes and done flags; a negedge monitor checks what the DUT shows.
module tb_fetch_arbiter;
    import fetch_arbiter_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int LEN = 8;
    localparam int RL  = 2;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_w = 1'b0, clr_if = 1'b0;
    logic [AW-1:0] w_base = '0, if_base = '0;
    logic          w_read = 1'b0, if_read = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          w_we, if_we;
    logic [DW-1:0] wdata;
    logic [2:0]    w_idx, if_idx;
    logic          w_done, if_done;

    fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .W_LEN(LEN), .IF_LEN(LEN), .RD_LAT(RL)) dut (
        .i_clk(clk), .i_rst(rst), .i_clr_w(clr_w), .i_clr_if(clr_if),
        .i_w_base(w_base), .i_if_base(if_base), .i_w_read(w_read), .i_if_read(if_read),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
        .o_w_buf_we(w_we), .o_if_buf_we(if_we), .o_buf_wdata(wdata),
        .o_w_buf_idx(w_idx), .o_if_buf_idx(if_idx), .o_w_done(w_done), .o_if_done(if_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return {a ^ 16'h1234, ~a, a, a + 16'hC0DE};
    endfunction

    // SRAM: data for the address presented RL cycles earlier.
    logic [AW-1:0] ma_pipe [RL];
    always @(posedge clk) begin
        ma_pipe[0] <= mem_addr;
        for (int i = 1; i < RL; i++) ma_pipe[i] <= ma_pipe[i-1];
    end
    assign mem_rdata = mdata(ma_pipe[RL-1]);

    typedef struct {int due; int own; bit gen; logic [AW-1:0] addr;} fl_t;
    typedef struct {int cyc; logic [AW-1:0] addr;} rq_t;
    typedef struct {int cyc; int idx; logic [DW-1:0] data;} wr_t;

    // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done.
    int            ph [2];
    int            icnt [2];
    int            rcnt [2];
    bit            gen [2];
    logic [AW-1:0] base [2];
    int            last_g = 1;
    fl_t           fl [$];
    rq_t           exp_rq [$];
    wr_t           exp_wr [2][$];
    bit            exp_done [2][MAXC];
    int            total = 0, bad = 0;
    bit            mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int t, input bit r, input bit cl [2],
                              input logic [AW-1:0] nb [2], input bit rd [2]);
        bit el [2];
        int win;
        fl_t f;
        if (r) begin
            fl.delete();
            for (int s = 0; s < 2; s++) begin
                ph[s] = 0; icnt[s] = 0; rcnt[s] = 0; gen[s] = 0;
                exp_done[s][t+1] = 0;
            end
            last_g = 1;
            return;
        end
        while (fl.size() > 0 && fl[0].due == t) begin
            f = fl.pop_front();
            if (f.gen == gen[f.own] && !cl[f.own]) begin
                exp_wr[f.own].push_back('{t, rcnt[f.own] % LEN, mdata(f.addr)});
                rcnt[f.own]++;
                if (rcnt[f.own] == LEN) ph[f.own] = 3;
            end
        end
        for (int s = 0; s < 2; s++) el[s] = (ph[s] == 1) && rd[s] && !cl[s];
        win = -1;
        if (el[0] && el[1]) win = 1 - last_g;
        else if (el[0])     win = 0;
        else if (el[1])     win = 1;
        if (win >= 0) begin
            logic [AW-1:0] a;
            a = base[win] + AW'(icnt[win]);
            exp_rq.push_back('{t + 1, a});
            fl.push_back('{t + 1 + RL, win, gen[win], a});
            icnt[win]++;
            if (icnt[win] == LEN) ph[win] = 2;
            last_g = win;
        end
        for (int s = 0; s < 2; s++) begin
            if (cl[s]) begin
                ph[s] = 1; icnt[s] = 0; rcnt[s] = 0; base[s] = nb[s]; gen[s] = ~gen[s];
            end
            exp_done[s][t+1] = (ph[s] == 3);
        end
    endtask

    task automatic drive(input bit r, input bit cw, input logic [AW-1:0] bw,
                         input bit ci, input logic [AW-1:0] bi, input bit rw, input bit ri);
        bit cl [2];
        bit rd [2];
        logic [AW-1:0] nb [2];
        @(posedge clk);
        #1;
        rst = r; clr_w = cw; w_base = bw; clr_if = ci; if_base = bi;
        w_read = rw; if_read = ri;
        cl[0] = cw; cl[1] = ci; rd[0] = rw; rd[1] = ri; nb[0] = bw; nb[1] = bi;
        model_step(cyc, r, cl, nb, rd);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_mem_req"},  64'(mem_req), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_w_we"},     64'(w_we), 64'd0);
        check({tag, "_if_we"},    64'(if_we), 64'd0);
        check({tag, "_w_idx"},    64'(w_idx), 64'd0);
        check({tag, "_if_idx"},   64'(if_idx), 64'd0);
        check({tag, "_w_done"},   64'(w_done), 64'd0);
        check({tag, "_if_done"},  64'(if_done), 64'd0);
    endtask

    task automatic mon_write(input int s, input logic we, input logic [2:0] idx);
        wr_t e;
        if (we) begin
            if (exp_wr[s].size() == 0) begin
                check(s == 0 ? "w_buf_we" : "if_buf_we", 64'(we), 64'd0);
            end else begin
                e = exp_wr[s].pop_front();
                check(s == 0 ? "w_wr_cyc" : "if_wr_cyc", 64'(cyc), 64'(e.cyc));
                check(s == 0 ? "w_buf_idx" : "if_buf_idx", 64'(idx), 64'(e.idx));
                check(s == 0 ? "w_wdata" : "if_wdata", wdata, e.data);
            end
        end else if (exp_wr[s].size() > 0 && exp_wr[s][0].cyc <= cyc) begin
            check(s == 0 ? "w_buf_we" : "if_buf_we", 64'(we), 64'd1);
            void'(exp_wr[s].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req) begin
                if (exp_rq.size() == 0) begin
                    check("mem_req", 64'(mem_req), 64'd0);
                end else begin
                    rq_t r;
                    r = exp_rq.pop_front();
                    check("req_cyc", 64'(cyc), 64'(r.cyc));
                    check("mem_addr", 64'(mem_addr), 64'(r.addr));
                end
            end else if (exp_rq.size() > 0 && exp_rq[0].cyc <= cyc) begin
                check("mem_req", 64'(mem_req), 64'd1);
                void'(exp_rq.pop_front());
            end
            mon_write(0, w_we, w_idx);
            mon_write(1, if_we, if_idx);
            check("w_done", 64'(w_done), 64'(exp_done[0][cyc]));
            check("if_done", 64'(if_done), 64'(exp_done[1][cyc]));
        end
    end

    initial begin
        int since_w, since_if;
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check_zero("reset");

        // Weights only.
        drive(0, 1, 16'h0100, 0, 0, 0, 0);
        repeat (16) drive(0, 0, 0, 0, 0, 1, 0);

        // Both streams together.
        drive(0, 1, 16'h0000, 1, 16'h0200, 0, 0);
        repeat (24) drive(0, 0, 0, 0, 0, 1, 1);

        // Stall after three issues.
        drive(0, 1, 16'h0300, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 1, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0);
        repeat (16) drive(0, 0, 0, 0, 0, 1, 0);

        // Clear with reads in flight.
        drive(0, 1, 16'h0500, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 1, 16'h0400, 0, 0, 1, 0);
        repeat (16) drive(0, 0, 0, 0, 0, 1, 0);

        // Address wrap.
        drive(0, 0, 0, 1, 16'hFFFE, 0, 0);
        repeat (16) drive(0, 0, 0, 0, 0, 0, 1);

        // Reset during active issue.
        drive(0, 1, 16'h0600, 1, 16'h0700, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        check_zero("midrst");
        repeat (6) drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 1, 16'h0800, 0, 0, 1, 1);
        repeat (16) drive(0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic with sparse clears and rare resets.
        since_w = 0; since_if = 0;
        for (int i = 0; i < 400; i++) begin
            bit r, cw, ci;
            r  = ($urandom_range(0, 199) == 0);
            cw = (since_w > 10) && ($urandom_range(0, 19) == 0);
            ci = (since_if > 10) && ($urandom_range(0, 19) == 0);
            since_w  = cw ? 0 : since_w + 1;
            since_if = ci ? 0 : since_if + 1;
            drive(r, cw, AW'($urandom), ci, AW'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        repeat (10) drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rq_left", 64'(exp_rq.size()), 64'd0);
        check("w_left", 64'(exp_wr[0].size()), 64'd0);
        check("if_left", 64'(exp_wr[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
